// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the memory-side controller.
// Holds the FSM encoding, operand-length codes and lane mask.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    RELEASE
  } state_e;

  localparam logic LEN_BYTE = 1'b0;
  localparam logic LEN_WORD = 1'b1;

  function automatic logic [3:0] lane_mask(
    input logic       len,
    input logic [1:0] addr
  );
    if (len == LEN_WORD) begin
      lane_mask = 4'hF;
    end else begin
      lane_mask = 4'b0001 << addr;
    end
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word-organised synchronous RAM with per-byte write enables
// and a registered read port; contents are never reset.
module mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge Clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_controller.sv
// Memory-side slave: latches a bus request, waits a fixed latency,
// then commits the access and pulses MemRdy (and MemErr if illegal).
module mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3,
  parameter int ADDR_W      = 24
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] MemAddr,
  input  logic [31:0]       toMemData,
  output logic [31:0]       fromMemData,
  input  logic              MemLength,
  input  logic              MemRd,
  input  logic              MemWr,
  input  logic              MemEnable,
  output logic              MemRdy,
  output logic              MemErr
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] widx_q;
  logic [1:0]    lane_q;
  logic [31:0]   data_q;
  logic          len_q;
  logic          rd_q;
  logic          wr_q;
  logic          rdy_q;
  logic          err_q;
  logic          rlen_q;
  logic [1:0]    rlane_q;

  logic          fire;
  logic          ram_we;
  logic          ram_re;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  // Upper address bits only select an alias of the array.
  logic unused_addr;
  assign unused_addr = ^MemAddr[ADDR_W-1:AW+2];

  assign fire      = (state_q == BUSY) && (cnt_q == '0) && !Reset;
  assign ram_we    = fire && wr_q && !rd_q;
  assign ram_re    = fire && rd_q && !wr_q;
  assign ram_be    = lane_mask(len_q, lane_q);
  assign ram_wdata = (len_q == LEN_WORD) ? data_q : {4{data_q[7:0]}};

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .Clk    (Clk),
    .Reset  (Reset),
    .we_i   (ram_we),
    .be_i   (ram_be),
    .re_i   (ram_re),
    .addr_i (widx_q),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      rlen_q  <= LEN_WORD;
      rlane_q <= 2'd0;
    end else begin
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (MemEnable && (MemRd || MemWr)) begin
            widx_q  <= MemAddr[AW+1:2];
            lane_q  <= MemAddr[1:0];
            data_q  <= toMemData;
            len_q   <= MemLength;
            rd_q    <= MemRd;
            wr_q    <= MemWr;
            cnt_q   <= CNT_INIT;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            rdy_q   <= 1'b1;
            err_q   <= rd_q && wr_q;
            if (ram_re) begin
              rlen_q  <= len_q;
              rlane_q <= lane_q;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= RELEASE;
        end
        RELEASE: begin
          if (!MemEnable) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Lane select uses the shape of the last completed read so the
  // value holds steady until another read finishes.
  always_comb begin
    fromMemData = ram_rdata;
    if (rlen_q == LEN_BYTE) begin
      unique case (rlane_q)
        2'd0:    fromMemData = {24'h0, ram_rdata[7:0]};
        2'd1:    fromMemData = {24'h0, ram_rdata[15:8]};
        2'd2:    fromMemData = {24'h0, ram_rdata[23:16]};
        default: fromMemData = {24'h0, ram_rdata[31:24]};
      endcase
    end
  end

  assign MemRdy = rdy_q;
  assign MemErr = err_q;

endmodule

// File: tb/tb_mem_controller.sv
// Scenario bench for mem_controller against a byte-array model
// with fixed-latency, wrapping, little-endian semantics.
module tb_mem_controller;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [23:0] MemAddr;
  logic [31:0] toMemData;
  logic [31:0] fromMemData;
  logic        MemLength;
  logic        MemRd;
  logic        MemWr;
  logic        MemEnable;
  logic        MemRdy;
  logic        MemErr;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  mdl [4096];
  logic [31:0] last_rd;

  mem_controller #(
    .DEPTH_WORDS(1024),
    .LATENCY    (3),
    .ADDR_W     (24)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .MemAddr    (MemAddr),
    .toMemData  (toMemData),
    .fromMemData(fromMemData),
    .MemLength  (MemLength),
    .MemRd      (MemRd),
    .MemWr      (MemWr),
    .MemEnable  (MemEnable),
    .MemRdy     (MemRdy),
    .MemErr     (MemErr)
  );

  always #5 Clk = ~Clk;

  function automatic void m_write(input logic len, input logic [23:0] a,
                                  input logic [31:0] d);
    int e;
    e = int'(a[11:0]);
    if (len) begin
      e = e & ~3;
      for (int b = 0; b < 4; b++) mdl[e+b] = d[8*b +: 8];
    end else begin
      mdl[e] = d[7:0];
    end
  endfunction

  function automatic logic [31:0] m_read(input logic len, input logic [23:0] a);
    int e;
    e = int'(a[11:0]);
    if (len) begin
      e = e & ~3;
      return {mdl[e+3], mdl[e+2], mdl[e+1], mdl[e]};
    end
    return {24'h0, mdl[e]};
  endfunction

  // One full handshake; inputs are scrambled after acceptance.
  task automatic req(input logic rd, input logic wr, input logic len,
                     input logic [23:0] a, input logic [31:0] d,
                     output int lat, output logic err,
                     output logic [31:0] q, output logic rdy_after);
    @(negedge Clk);
    MemRd = rd; MemWr = wr; MemLength = len;
    MemAddr = a; toMemData = d; MemEnable = 1'b1;
    @(posedge Clk); #1;
    MemAddr   = 24'($urandom);
    toMemData = $urandom;
    MemRd     = 1'($urandom);
    MemWr     = 1'($urandom);
    MemLength = 1'($urandom);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge Clk); #1;
      if (MemRdy) begin
        lat = i;
        break;
      end
    end
    err = MemErr;
    q   = fromMemData;
    @(posedge Clk); #1;
    rdy_after = MemRdy;
    MemEnable = 1'b0; MemRd = 1'b0; MemWr = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; MemEnable = 1'b1; MemRd = 1'b1; MemWr = 1'b0;
    MemLength = 1'b1; MemAddr = 24'h0; toMemData = 32'h0;
    repeat (3) @(posedge Clk);
    #1;
    vectors++;
    if (MemRdy !== 1'b0) begin miscompares++; $display("FAIL reset_rdy got %b want 0", MemRdy); end
    vectors++;
    if (MemErr !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", MemErr); end
    vectors++;
    if (fromMemData !== 32'h0) begin miscompares++; $display("FAIL reset_data got %h want 0", fromMemData); end
    MemEnable = 1'b0; MemRd = 1'b0; Reset = 1'b0;
    last_rd = 32'h0;
    @(posedge Clk); #1;
  endtask

  task automatic test_word();
    int lat; logic err, ra; logic [31:0] q;
    req(1'b0, 1'b1, 1'b1, 24'h000010, 32'hDEADBEEF, lat, err, q, ra);
    m_write(1'b1, 24'h000010, 32'hDEADBEEF);
    vectors++;
    if (lat != 3) begin miscompares++; $display("FAIL word_wr_lat got %0d want 3", lat); end
    vectors++;
    if (q !== last_rd) begin miscompares++; $display("FAIL word_wr_hold got %h want %h", q, last_rd); end
    vectors++;
    if (ra !== 1'b0) begin miscompares++; $display("FAIL word_wr_pulse got %b want 0", ra); end
    req(1'b1, 1'b0, 1'b1, 24'h000010, 32'h0, lat, err, q, ra);
    last_rd = 32'hDEADBEEF;
    vectors++;
    if (lat != 3) begin miscompares++; $display("FAIL word_rd_lat got %0d want 3", lat); end
    vectors++;
    if (q !== 32'hDEADBEEF) begin miscompares++; $display("FAIL word_rd_data got %h want deadbeef", q); end
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL word_rd_err got %b want 0", err); end
  endtask

  task automatic test_byte_lane();
    int lat; logic err, ra; logic [31:0] q;
    req(1'b0, 1'b1, 1'b1, 24'h000020, 32'h11223344, lat, err, q, ra);
    m_write(1'b1, 24'h000020, 32'h11223344);
    req(1'b0, 1'b1, 1'b0, 24'h000022, 32'h5566_77AA, lat, err, q, ra);
    m_write(1'b0, 24'h000022, 32'h556677AA);
    vectors++;
    if (lat != 3) begin miscompares++; $display("FAIL byte_wr_lat got %0d want 3", lat); end
    req(1'b1, 1'b0, 1'b1, 24'h000020, 32'h0, lat, err, q, ra);
    vectors++;
    if (q !== 32'h11AA3344) begin miscompares++; $display("FAIL byte_word_rd got %h want 11aa3344", q); end
    req(1'b1, 1'b0, 1'b0, 24'h000023, 32'h0, lat, err, q, ra);
    vectors++;
    if (q !== 32'h00000011) begin miscompares++; $display("FAIL byte_rd_lane3 got %h want 00000011", q); end
    req(1'b1, 1'b0, 1'b0, 24'h000022, 32'h0, lat, err, q, ra);
    last_rd = 32'h000000AA;
    vectors++;
    if (q !== 32'h000000AA) begin miscompares++; $display("FAIL byte_rd_lane2 got %h want 000000aa", q); end
  endtask

  task automatic test_wrap();
    int lat; logic err, ra; logic [31:0] q;
    req(1'b0, 1'b1, 1'b1, 24'h001003, 32'h5A5A5A5A, lat, err, q, ra);
    m_write(1'b1, 24'h001003, 32'h5A5A5A5A);
    req(1'b1, 1'b0, 1'b1, 24'h000000, 32'h0, lat, err, q, ra);
    last_rd = 32'h5A5A5A5A;
    vectors++;
    if (q !== 32'h5A5A5A5A) begin miscompares++; $display("FAIL wrap_rd got %h want 5a5a5a5a", q); end
  endtask

  task automatic test_illegal();
    int lat; logic err, ra; logic [31:0] q;
    req(1'b0, 1'b1, 1'b1, 24'h000040, 32'h12345678, lat, err, q, ra);
    m_write(1'b1, 24'h000040, 32'h12345678);
    req(1'b1, 1'b1, 1'b1, 24'h000040, 32'hFFFFFFFF, lat, err, q, ra);
    vectors++;
    if (lat != 3) begin miscompares++; $display("FAIL illegal_lat got %0d want 3", lat); end
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL illegal_err got %b want 1", err); end
    vectors++;
    if (q !== last_rd) begin miscompares++; $display("FAIL illegal_hold got %h want %h", q, last_rd); end
    vectors++;
    if (ra !== 1'b0) begin miscompares++; $display("FAIL illegal_pulse got %b want 0", ra); end
    req(1'b1, 1'b0, 1'b1, 24'h000040, 32'h0, lat, err, q, ra);
    last_rd = 32'h12345678;
    vectors++;
    if (q !== 32'h12345678) begin miscompares++; $display("FAIL illegal_after got %h want 12345678", q); end
  endtask

  task automatic test_enable_hold();
    int lat, pulses, first; logic err, ra; logic [31:0] q, d;
    d = $urandom;
    @(negedge Clk);
    MemRd = 1'b0; MemWr = 1'b1; MemLength = 1'b1;
    MemAddr = 24'h000300; toMemData = d; MemEnable = 1'b1;
    m_write(1'b1, 24'h000300, d);
    @(posedge Clk); #1;
    pulses = 0; first = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge Clk); #1;
      if (MemRdy) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    vectors++;
    if (pulses != 1) begin miscompares++; $display("FAIL hold_pulses got %0d want 1", pulses); end
    vectors++;
    if (first != 3) begin miscompares++; $display("FAIL hold_lat got %0d want 3", first); end
    MemEnable = 1'b0; MemWr = 1'b0;
    @(posedge Clk); #1;
    req(1'b1, 1'b0, 1'b1, 24'h000300, 32'h0, lat, err, q, ra);
    last_rd = d;
    vectors++;
    if (lat != 3) begin miscompares++; $display("FAIL hold_next_lat got %0d want 3", lat); end
    vectors++;
    if (q !== d) begin miscompares++; $display("FAIL hold_next_data got %h want %h", q, d); end
  endtask

  task automatic test_reset_mid_write();
    int lat, pulses; logic err, ra; logic [31:0] q, old;
    old = $urandom & 32'h7FFF_FFFF;
    req(1'b0, 1'b1, 1'b1, 24'h000080, old, lat, err, q, ra);
    m_write(1'b1, 24'h000080, old);
    @(negedge Clk);
    MemRd = 1'b0; MemWr = 1'b1; MemLength = 1'b1;
    MemAddr = 24'h000080; toMemData = 32'hFFFFFFFF; MemEnable = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0; MemEnable = 1'b0; MemWr = 1'b0;
    last_rd = 32'h0;
    vectors++;
    if (MemErr !== 1'b0) begin miscompares++; $display("FAIL rst_mid_err got %b want 0", MemErr); end
    pulses = MemRdy ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      if (MemRdy) pulses++;
    end
    vectors++;
    if (pulses != 0) begin miscompares++; $display("FAIL rst_mid_pulses got %0d want 0", pulses); end
    req(1'b1, 1'b0, 1'b1, 24'h000080, 32'h0, lat, err, q, ra);
    last_rd = old;
    vectors++;
    if (q !== old) begin miscompares++; $display("FAIL rst_mid_old got %h want %h", q, old); end
  endtask

  task automatic test_back_to_back();
    int lat; logic err, ra; logic [31:0] q, d, exp;
    logic [23:0] a;
    for (int n = 0; n < 6; n++) begin
      a = 24'($urandom_range(0, 4095)) | 24'($urandom_range(0, 4095) << 12);
      d = $urandom;
      req(1'b0, 1'b1, 1'(n & 1), a, d, lat, err, q, ra);
      m_write(1'(n & 1), a, d);
      req(1'b1, 1'b0, 1'b1, a, 32'h0, lat, err, q, ra);
      exp = m_read(1'b1, a);
      last_rd = exp;
      vectors++;
      if (q !== exp) begin miscompares++; $display("FAIL b2b_%0d got %h want %h", n, q, exp); end
    end
  endtask

  task automatic test_random();
    int lat, kind; logic err, ra, len, rd, wr; logic [31:0] q, d, exp;
    logic [23:0] a;
    for (int w = 0; w < 64; w++) begin
      a = 24'(12'h100 + 4*w);
      d = $urandom;
      req(1'b0, 1'b1, 1'b1, a, d, lat, err, q, ra);
      m_write(1'b1, a, d);
    end
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      rd   = (kind == 0) || (kind >= 5);
      wr   = (kind <= 4);
      len  = 1'($urandom);
      a    = 24'(12'h100 + $urandom_range(0, 255)) | 24'($urandom_range(0, 4095) << 12);
      d    = $urandom;
      req(rd, wr, len, a, d, lat, err, q, ra);
      if (rd && !wr) begin
        exp = m_read(len, a);
        last_rd = exp;
      end else begin
        exp = last_rd;
        if (wr && !rd) m_write(len, a, d);
      end
      vectors++;
      if (lat != 3 || err !== (rd & wr) || ra !== 1'b0)
        begin miscompares++; $display("FAIL rnd_hs_%0d lat %0d err %b want lat 3 err %b", n, lat, err, rd & wr); end
      vectors++;
      if (q !== exp) begin miscompares++; $display("FAIL rnd_data_%0d got %h want %h", n, q, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lane();
    test_wrap();
    test_illegal();
    test_enable_hold();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
